// File: rtl/id_stage_hazard.sv
// id_stage_hazard: decode stage for a 5-stage MIPS pipeline.
// Decodes the IF/ID instruction, reads a 32-entry register file with
// write-through bypass, resolves beq in ID with MEM-stage forwarding,
// raises load-use / branch-operand stalls and owns the ID/EX register.
// Optional feature macro: ID_BNE_EN (adds bne, opcode 0x05).
module id_stage_hazard #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [31:0]       if_instr_i,
    input  logic [PC_W-1:0]   if_pc_plus4_i,
    input  logic              mem_regwrite_i,
    input  logic              mem_memread_i,
    input  logic [4:0]        mem_waddr_i,
    input  logic [DATA_W-1:0] mem_alu_i,
    input  logic              wb_regwrite_i,
    input  logic [4:0]        wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    output logic              stall_o,
    output logic              flush_o,
    output logic [PC_W-1:0]   branch_target_o,
    output logic              ex_valid_o,
    output logic              ex_regwrite_o,
    output logic              ex_memtoreg_o,
    output logic              ex_memread_o,
    output logic              ex_memwrite_o,
    output logic              ex_alusrc_o,
    output logic              ex_regdst_o,
    output logic [1:0]        ex_aluop_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [5:0]        ex_funct_o,
    output logic [4:0]        ex_rs_addr_o,
    output logic [4:0]        ex_rt_addr_o,
    output logic [4:0]        ex_rd_addr_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef ID_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'h05;
`endif

    // Instruction fields
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode = if_instr_i[31:26];
    assign rs     = if_instr_i[25:21];
    assign rt     = if_instr_i[20:16];
    assign rd     = if_instr_i[15:11];
    assign funct  = if_instr_i[5:0];
    assign imm    = if_instr_i[15:0];

    // Decoded controls
    logic       c_regwrite;
    logic       c_memtoreg;
    logic       c_memread;
    logic       c_memwrite;
    logic       c_alusrc;
    logic       c_regdst;
    logic [1:0] c_aluop;
    logic       c_branch;
    logic       c_branch_ne;
    logic       c_uses_rt;

    // Main decoder: unknown opcodes fall through to an all-zero NOP
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal
        // unassigned, which would otherwise infer a latch.
        c_regwrite  = 1'b0;
        c_memtoreg  = 1'b0;
        c_memread   = 1'b0;
        c_memwrite  = 1'b0;
        c_alusrc    = 1'b0;
        c_regdst    = 1'b0;
        c_aluop     = 2'b00;
        c_branch    = 1'b0;
        c_branch_ne = 1'b0;
        c_uses_rt   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                c_regwrite = 1'b1;
                c_regdst   = 1'b1;
                c_aluop    = 2'b10;
                c_uses_rt  = 1'b1;
            end
            OP_LW: begin
                c_regwrite = 1'b1;
                c_memtoreg = 1'b1;
                c_memread  = 1'b1;
                c_alusrc   = 1'b1;
            end
            OP_SW: begin
                c_memwrite = 1'b1;
                c_alusrc   = 1'b1;
                c_uses_rt  = 1'b1;
            end
            OP_ADDI: begin
                c_regwrite = 1'b1;
                c_alusrc   = 1'b1;
            end
            OP_BEQ: begin
                c_branch  = 1'b1;
                c_aluop   = 2'b01;
                c_uses_rt = 1'b1;
            end
`ifdef ID_BNE_EN
            OP_BNE: begin
                c_branch    = 1'b1;
                c_branch_ne = 1'b1;
                c_aluop     = 2'b01;
                c_uses_rt   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Register file storage
    logic [DATA_W-1:0] rf [32];
    logic              wb_we;

    assign wb_we = wb_regwrite_i && (wb_waddr_i != 5'd0);

    // Register file write port; reset clears every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: this memory is reset explicitly so a mid-run reset makes
            // every register read back as zero; it therefore maps to flops.
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else if (wb_we) begin
            rf[wb_waddr_i] <= wb_wdata_i;
        end
    end

    // Register reads with write-through bypass from WB; $0 is hardwired
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;

    // Read ports: $0 reads zero, a same-cycle WB write wins over stored data
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0) rs_val = (wb_we && wb_waddr_i == rs) ? wb_wdata_i : rf[rs];
        if (rt != 5'd0) rt_val = (wb_we && wb_waddr_i == rt) ? wb_wdata_i : rf[rt];
    end

    // Hazard detection
    logic [4:0] ex_dest;
    logic       load_use;
    logic       br_stall_ex;
    logic       br_stall_mem;

    assign ex_dest = ex_regdst_o ? ex_rd_addr_o : ex_rt_addr_o;

    assign load_use = ex_valid_o && ex_memread_o && (ex_rt_addr_o != 5'd0) &&
                      ((ex_rt_addr_o == rs) || (c_uses_rt && ex_rt_addr_o == rt));

    // Branch operand still being produced in EX
    assign br_stall_ex = c_branch && ex_regwrite_o &&
                         (((rs != 5'd0) && (rs == ex_dest)) ||
                          ((rt != 5'd0) && (rt == ex_dest)));

    // Branch operand is a load sitting in MEM; its data is not ready yet
    assign br_stall_mem = c_branch && mem_memread_i &&
                          ((rs == mem_waddr_i) || (rt == mem_waddr_i));

    assign stall_o = if_valid_i && (load_use || br_stall_ex || br_stall_mem);

    // Branch comparison with EX/MEM ALU forwarding
    logic              fwd_ok;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              ops_equal;
    logic              taken;

    assign fwd_ok    = mem_regwrite_i && !mem_memread_i && (mem_waddr_i != 5'd0);
    assign op_a      = (fwd_ok && mem_waddr_i == rs) ? mem_alu_i : rs_val;
    assign op_b      = (fwd_ok && mem_waddr_i == rt) ? mem_alu_i : rt_val;
    assign ops_equal = (op_a == op_b);
    assign taken     = c_branch_ne ? !ops_equal : ops_equal;
    assign flush_o   = if_valid_i && c_branch && taken && !stall_o;

    // Immediate and branch target (wraps modulo 2^PC_W)
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   br_offset;

    assign imm_ext         = {{(DATA_W-16){imm[15]}}, imm};
    assign br_offset       = {{(PC_W-18){imm[15]}}, imm, 2'b00};
    assign branch_target_o = if_pc_plus4_i + br_offset;

    logic capture;
    assign capture = if_valid_i && !stall_o;

    // ID/EX pipeline register: bubble on reset, invalid input or stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst || !capture) begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_alusrc_o   <= 1'b0;
            ex_regdst_o   <= 1'b0;
            ex_aluop_o    <= 2'b00;
            ex_rs_data_o  <= '0;
            ex_rt_data_o  <= '0;
            ex_imm_o      <= '0;
            ex_funct_o    <= '0;
            ex_rs_addr_o  <= '0;
            ex_rt_addr_o  <= '0;
            ex_rd_addr_o  <= '0;
        end else begin
            ex_valid_o    <= 1'b1;
            ex_regwrite_o <= c_regwrite;
            ex_memtoreg_o <= c_memtoreg;
            ex_memread_o  <= c_memread;
            ex_memwrite_o <= c_memwrite;
            ex_alusrc_o   <= c_alusrc;
            ex_regdst_o   <= c_regdst;
            ex_aluop_o    <= c_aluop;
            ex_rs_data_o  <= rs_val;
            ex_rt_data_o  <= rt_val;
            ex_imm_o      <= imm_ext;
            ex_funct_o    <= funct;
            ex_rs_addr_o  <= rs;
            ex_rt_addr_o  <= rt;
            ex_rd_addr_o  <= rd;
        end
    end

endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard: table-driven decode vectors plus directed multi-cycle
// sequences for bypass, load-use, branch hazards, forwarding and reset.
module tb_id_stage_hazard;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_plus4_i;
    logic        mem_regwrite_i;
    logic        mem_memread_i;
    logic [4:0]  mem_waddr_i;
    logic [31:0] mem_alu_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_waddr_i;
    logic [31:0] wb_wdata_i;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] branch_target_o;
    logic        ex_valid_o;
    logic        ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o;
    logic        ex_alusrc_o, ex_regdst_o;
    logic [1:0]  ex_aluop_o;
    logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [5:0]  ex_funct_o;
    logic [4:0]  ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;

    id_stage_hazard #(.DATA_W(32), .PC_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid_i      (if_valid_i),
        .if_instr_i      (if_instr_i),
        .if_pc_plus4_i   (if_pc_plus4_i),
        .mem_regwrite_i  (mem_regwrite_i),
        .mem_memread_i   (mem_memread_i),
        .mem_waddr_i     (mem_waddr_i),
        .mem_alu_i       (mem_alu_i),
        .wb_regwrite_i   (wb_regwrite_i),
        .wb_waddr_i      (wb_waddr_i),
        .wb_wdata_i      (wb_wdata_i),
        .stall_o         (stall_o),
        .flush_o         (flush_o),
        .branch_target_o (branch_target_o),
        .ex_valid_o      (ex_valid_o),
        .ex_regwrite_o   (ex_regwrite_o),
        .ex_memtoreg_o   (ex_memtoreg_o),
        .ex_memread_o    (ex_memread_o),
        .ex_memwrite_o   (ex_memwrite_o),
        .ex_alusrc_o     (ex_alusrc_o),
        .ex_regdst_o     (ex_regdst_o),
        .ex_aluop_o      (ex_aluop_o),
        .ex_rs_data_o    (ex_rs_data_o),
        .ex_rt_data_o    (ex_rt_data_o),
        .ex_imm_o        (ex_imm_o),
        .ex_funct_o      (ex_funct_o),
        .ex_rs_addr_o    (ex_rs_addr_o),
        .ex_rt_addr_o    (ex_rt_addr_o),
        .ex_rd_addr_o    (ex_rd_addr_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_valid_i     = 1'b0;
        if_instr_i     = '0;
        if_pc_plus4_i  = '0;
        mem_regwrite_i = 1'b0;
        mem_memread_i  = 1'b0;
        mem_waddr_i    = '0;
        mem_alu_i      = '0;
        wb_regwrite_i  = 1'b0;
        wb_waddr_i     = '0;
        wb_wdata_i     = '0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        idle_inputs();
        wb_regwrite_i = 1'b1;
        wb_waddr_i    = a;
        wb_wdata_i    = d;
        tick();
        wb_regwrite_i = 1'b0;
    endtask

    function automatic logic [7:0] ctrl_now();
        return {ex_regwrite_o, ex_memtoreg_o, ex_memread_o, ex_memwrite_o,
                ex_alusrc_o, ex_regdst_o, ex_aluop_o};
    endfunction

    typedef struct {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        wb_we;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        stall;
        logic        flush;
        logic [31:0] target;
        logic        ex_valid;
        logic [7:0]  ctrl;
        logic [31:0] rs_d;
        logic [31:0] rt_d;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[10];

`ifdef ID_BNE_EN
    localparam logic       BNE_FLUSH = 1'b1;
    localparam logic [7:0] BNE_CTRL  = 8'h01;
`else
    localparam logic       BNE_FLUSH = 1'b0;
    localparam logic [7:0] BNE_CTRL  = 8'h00;
`endif

    initial begin
        // ctrl = {regwrite, memtoreg, memread, memwrite, alusrc, regdst, aluop[1:0]}
        //          valid instr         pc4           wb_we addr data         stl flu target        exv ctrl   rs_d   rt_d   imm
        vecs[0] = '{1'b1, 32'h00224820, 32'h100, 1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h12180, 1'b1, 8'h86, 32'h1,  32'h2, 32'h4820};     // add $9,$1,$2
        vecs[1] = '{1'b1, 32'h8C2AFFFC, 32'h200, 1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h1F0,   1'b1, 8'hE8, 32'h1,  32'h0, 32'hFFFFFFFC}; // lw $10,-4($1)
        vecs[2] = '{1'b1, 32'hACC20008, 32'h300, 1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h320,   1'b1, 8'h18, 32'h55, 32'h2, 32'h8};        // sw $2,8($6)
        vecs[3] = '{1'b1, 32'h204B7FFF, 32'h10,  1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h2000C, 1'b1, 8'h88, 32'h2,  32'h0, 32'h7FFF};     // addi $11,$2,0x7fff
        vecs[4] = '{1'b1, 32'h10220002, 32'h40,  1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h48,    1'b1, 8'h01, 32'h1,  32'h2, 32'h2};        // beq $1,$2,+2 (not taken)
        vecs[5] = '{1'b1, 32'h1042FFFF, 32'h40,  1'b0, 5'd0, 32'h0,     1'b0, 1'b1, 32'h3C,    1'b1, 8'h01, 32'h2,  32'h2, 32'hFFFFFFFF}; // beq $2,$2,-1 (taken)
        vecs[6] = '{1'b1, 32'h1422FFFF, 32'h40,  1'b0, 5'd0, 32'h0,     1'b0, BNE_FLUSH, 32'h3C, 1'b1, BNE_CTRL, 32'h1, 32'h2, 32'hFFFFFFFF}; // bne $1,$2,-1
        vecs[7] = '{1'b1, 32'hFC220005, 32'h0,   1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h14,    1'b1, 8'h00, 32'h1,  32'h2, 32'h5};        // unknown opcode
        vecs[8] = '{1'b0, 32'h1042FFFF, 32'h40,  1'b0, 5'd0, 32'h0,     1'b0, 1'b0, 32'h3C,    1'b0, 8'h00, 32'h0,  32'h0, 32'h0};        // invalid beq -> bubble
        vecs[9] = '{1'b1, 32'h00001820, 32'h0,   1'b1, 5'd0, 32'hDEAD,  1'b0, 1'b0, 32'h6080,  1'b1, 8'h86, 32'h0,  32'h0, 32'h1820};     // add $3,$0,$0, WB to $0

        idle_inputs();
        rst = 1'b1;
        #12;
        check("reset_ex_valid", ex_valid_o, 1'b0);
        check("reset_ctrl", ctrl_now(), 8'h00);
        check("reset_rs_data", ex_rs_data_o, 32'h0);
        check("reset_stall", stall_o, 1'b0);
        check("reset_flush", flush_o, 1'b0);
        rst = 1'b0;
        tick();

        // Register preload through the WB port
        wb_write(5'd1, 32'h1);
        wb_write(5'd2, 32'h2);
        wb_write(5'd6, 32'h55);
        wb_write(5'd5, 32'hAB);

        // Table-driven single-cycle decode vectors
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if_valid_i    = vecs[i].valid;
            if_instr_i    = vecs[i].instr;
            if_pc_plus4_i = vecs[i].pc4;
            wb_regwrite_i = vecs[i].wb_we;
            wb_waddr_i    = vecs[i].wb_addr;
            wb_wdata_i    = vecs[i].wb_data;
            #1;
            check($sformatf("v%0d_stall", i), stall_o, vecs[i].stall);
            check($sformatf("v%0d_flush", i), flush_o, vecs[i].flush);
            check($sformatf("v%0d_target", i), branch_target_o, vecs[i].target);
            tick();
            check($sformatf("v%0d_ex_valid", i), ex_valid_o, vecs[i].ex_valid);
            check($sformatf("v%0d_ctrl", i), ctrl_now(), vecs[i].ctrl);
            check($sformatf("v%0d_rs_data", i), ex_rs_data_o, vecs[i].rs_d);
            check($sformatf("v%0d_rt_data", i), ex_rt_data_o, vecs[i].rt_d);
            check($sformatf("v%0d_imm", i), ex_imm_o, vecs[i].imm);
        end

        // WB write-through bypass: $8=0x1234 while ID reads add $9,$8,$8
        idle_inputs();
        if_valid_i = 1'b1; if_instr_i = 32'h01084820;
        wb_regwrite_i = 1'b1; wb_waddr_i = 5'd8; wb_wdata_i = 32'h1234;
        tick();
        check("bypass_rs", ex_rs_data_o, 32'h1234);
        check("bypass_rt", ex_rt_data_o, 32'h1234);
        check("bypass_ctrl", ctrl_now(), 8'h86);
        check("bypass_rd", ex_rd_addr_o, 5'd9);
        check("bypass_funct", ex_funct_o, 6'h20);
        wb_regwrite_i = 1'b0;
        tick();
        check("rf_written_rs", ex_rs_data_o, 32'h1234);

        // Load-use: lw $2,0($1) in ID/EX, add $3,$2,$4 in ID; WB writes $2 during the stall
        idle_inputs();
        if_valid_i = 1'b1; if_instr_i = 32'h8C220000;
        tick();
        if_instr_i = 32'h00441820;
        wb_regwrite_i = 1'b1; wb_waddr_i = 5'd2; wb_wdata_i = 32'h77;
        #1;
        check("lu_stall", stall_o, 1'b1);
        check("lu_flush", flush_o, 1'b0);
        tick();
        wb_regwrite_i = 1'b0;
        check("lu_bubble_valid", ex_valid_o, 1'b0);
        check("lu_bubble_memread", ex_memread_o, 1'b0);
        #1;
        check("lu_stall_drop", stall_o, 1'b0);
        tick();
        check("lu_add_valid", ex_valid_o, 1'b1);
        check("lu_add_rs_addr", ex_rs_addr_o, 5'd2);
        check("lu_add_rt_addr", ex_rt_addr_o, 5'd4);
        check("lu_add_rd_addr", ex_rd_addr_o, 5'd3);
        check("lu_new_rs_data", ex_rs_data_o, 32'h77);

        // Branch forwarding from EX/MEM: beq $7,$6,+3 with MEM $7=0x55
        idle_inputs();
        tick();
        if_valid_i = 1'b1; if_instr_i = 32'h10E60003; if_pc_plus4_i = 32'h100;
        mem_regwrite_i = 1'b1; mem_waddr_i = 5'd7; mem_alu_i = 32'h55;
        #1;
        check("fwd_stall", stall_o, 1'b0);
        check("fwd_flush", flush_o, 1'b1);
        check("fwd_target", branch_target_o, 32'h10C);
        mem_memread_i = 1'b1;
        #1;
        check("mem_load_stall", stall_o, 1'b1);
        check("mem_load_flush", flush_o, 1'b0);

        // Branch operand produced in EX: add $7,$1,$2 then beq $7,$6,+1
        idle_inputs();
        tick();
        if_valid_i = 1'b1; if_instr_i = 32'h00223820;
        tick();
        if_instr_i = 32'h10E60001; if_pc_plus4_i = 32'h80;
        #1;
        check("ex_br_stall", stall_o, 1'b1);
        check("ex_br_flush", flush_o, 1'b0);
        tick();
        mem_regwrite_i = 1'b1; mem_waddr_i = 5'd7; mem_alu_i = 32'h55;
        #1;
        check("ex_br_resolved_stall", stall_o, 1'b0);
        check("ex_br_resolved_flush", flush_o, 1'b1);
        check("ex_br_target", branch_target_o, 32'h84);
        mem_alu_i = 32'h3;
        #1;
        check("ex_br_fwd_ne_flush", flush_o, 1'b0);

        // Reset asserted mid-stall
        idle_inputs();
        tick();
        if_valid_i = 1'b1; if_instr_i = 32'h8C220000;
        tick();
        if_instr_i = 32'h00441820;
        #1;
        check("rst_pre_stall", stall_o, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_ex_valid", ex_valid_o, 1'b0);
        check("rst_ex_memread", ex_memread_o, 1'b0);
        check("rst_stall_drop", stall_o, 1'b0);
        tick();
        rst = 1'b0;
        if_instr_i = 32'h00A84820;  // add $9,$5,$8
        tick();
        check("rst_rf5_cleared", ex_rs_data_o, 32'h0);
        check("rst_rf8_cleared", ex_rt_data_o, 32'h0);
        check("rst_after_valid", ex_valid_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
